pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencing controller for the five-stage integer core; it sits between the per-stage stall requesters and the PC register. It merges stall requests into the 6-bit `stall` vector and generates the fetch chip-enable. It owns branch redirect towards the PC: it forwards or buffers `branch_flag`/target so that a branch resolved in ID while fetch is blocked is never lost.

## Interface
Parameters:
- BOOT_CYCLES, 2: cycles `ce` stays disabled after reset release (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- stallreq_if  input  1  instruction memory not ready.
- stallreq_id  input  1  ID stage hazard (load-use).
- stallreq_ex  input  1  EX multi-cycle op busy.
- stallreq_mem  input  1  data memory not ready.
- branch_flag_i  input  1  ID resolved a taken branch this cycle.
- branch_target_address_i  input  32  target of that branch.
- stall  output  6  stall vector: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
- ce  output  1  fetch enable, 1 = enabled.
- branch_flag_o  output  1  redirect PC this cycle.
- branch_target_address_o  output  32  redirect target.
- flush  output  1  kill the instruction currently in IF/ID.

## Operation
- States: BOOT, RUN, PEND.
- BOOT: boot counter counts up from 0. `ce`=0, stall=6'b000000, no redirect. When counter reaches BOOT_CYCLES-1, next state is RUN.
- stall vector (combinational in RUN/PEND, priority high to low):
  - stallreq_mem -> 6'b011111
  - stallreq_ex -> 6'b001111
  - stallreq_id -> 6'b000111
  - stallreq_if -> 6'b000011
  - none -> 6'b000000
- Branch acceptance in RUN, on branch_flag_i=1:
  - stall[2]=1: ignored; ID holds and re-presents the branch.
  - stall[0]=0: forwarded the same cycle. branch_flag_o=1, target passed through.
  - stall[0]=1 and stall[2]=0 (IF-only stall): target latched into pend_target, next state PEND, branch_flag_o=0.
- PEND:
  - branch_flag_o=0 while stall[0]=1.
  - First cycle with stall[0]=0: branch_flag_o=1 with pend_target, then next state RUN.
  - A new branch_flag_i with stall[2]=0 in PEND overwrites pend_target (newest wins).
- Reset mid-operation: returns to BOOT immediately; pend_target is discarded.

## Timing
- Reset values: state=BOOT, ce=0, stall=0, branch_flag_o=0, branch_target_address_o=0, flush=0, pend_target=0, boot counter=0.
- `ce` is registered. It rises on the clock edge that leaves BOOT, so it is low for exactly BOOT_CYCLES rising edges after rst deasserts.
- stall, branch_flag_o, branch_target_address_o and flush are combinational from inputs and state. Zero-cycle latency when forwarding.
- A buffered branch is released with a latency of 1 cycle after the last IF stall cycle.
- branch_target_address_o is 0 whenever branch_flag_o=0.
- stall is forced to 0 whenever ce=0.

## Configuration
- Macro `PIPE_CTRL_DELAY_SLOT_EN`.
- Defined: MIPS branch delay slot. flush is tied to 0, and the instruction in IF/ID after a branch executes.
- Undefined: flush=1 in exactly the cycle branch_flag_o=1. This applies to both the forwarded and the buffered release.

## Test plan
- Reset/boot: with BOOT_CYCLES=2, release rst. ce=0 for 2 edges, then 1. stall=0 and branch_flag_o=0 throughout.
- Stall priority: assert stallreq_if and stallreq_ex together -> stall=6'b001111. Add stallreq_mem -> 6'b011111. Deassert all -> 6'b000000.
- Forwarded branch: no stalls, branch_flag_i=1, target 32'h0000_0040. The same cycle gives branch_flag_o=1 and target 32'h40. flush=1 without the macro, 0 with it.
- Buffered branch: stallreq_if held 3 cycles with branch_flag_i=1, target 32'h100, pulsed in cycle 1. branch_flag_o stays 0 for cycles 1-3. Cycle 4 (stallreq_if=0) gives branch_flag_o=1 and target 32'h100, then 0.
- ID-stalled branch ignored: stallreq_id=1 and branch_flag_i=1 for 2 cycles, then the stall clears with branch still asserted. Exactly one redirect pulse, in the unstalled cycle, and state never enters PEND.
- Reset in PEND: latch target 32'h200, assert rst. All outputs go to reset values asynchronously. After boot, no redirect to 32'h200 ever occurs.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall-vector merge, boot-gated fetch enable, branch redirect buffer.
// Define PIPE_CTRL_DELAY_SLOT_EN for a MIPS delay slot (flush tied low).
module pipe_ctrl #(
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic [5:0]  stall,
  output logic        ce,
  output logic        branch_flag_o,
  output logic [31:0] branch_target_address_o,
  output logic        flush
);

  typedef enum logic [1:0] {StBoot, StRun, StPend} state_e;

  localparam logic [3:0] BootLast = 4'(BOOT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        ce_q, ce_d;
  logic [5:0]  stall_req;
  logic        accept;

  always_comb begin
    stall_req = 6'b000000;
    if (stallreq_mem)      stall_req = 6'b011111;
    else if (stallreq_ex)  stall_req = 6'b001111;
    else if (stallreq_id)  stall_req = 6'b000111;
    else if (stallreq_if)  stall_req = 6'b000011;
  end

  // ce is low exactly while in boot, so this also silences stalls there.
  assign stall = ce_q ? stall_req : 6'b000000;
  assign ce    = ce_q;

  // A branch seen while ID is stalled will be re-presented, so it is not taken here.
  assign accept = branch_flag_i && !stall[2];

  always_comb begin
    state_d                 = state_q;
    boot_cnt_d              = boot_cnt_q;
    pend_target_d           = pend_target_q;
    branch_flag_o           = 1'b0;
    branch_target_address_o = 32'h0;
    unique case (state_q)
      StBoot: begin
        if (boot_cnt_q == BootLast) begin
          state_d    = StRun;
          boot_cnt_d = 4'd0;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end
      StRun: begin
        if (accept) begin
          if (!stall[0]) begin
            branch_flag_o           = 1'b1;
            branch_target_address_o = branch_target_address_i;
          end else begin
            pend_target_d = branch_target_address_i;
            state_d       = StPend;
          end
        end
      end
      StPend: begin
        if (!stall[0]) begin
          // Newest branch wins even in the release cycle.
          branch_flag_o           = 1'b1;
          branch_target_address_o = accept ? branch_target_address_i : pend_target_q;
          pend_target_d           = 32'h0;
          state_d                 = StRun;
        end else if (accept) begin
          pend_target_d = branch_target_address_i;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  assign ce_d = (state_d != StBoot);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StBoot;
      boot_cnt_q    <= 4'd0;
      pend_target_q <= 32'h0;
      ce_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      boot_cnt_q    <= boot_cnt_d;
      pend_target_q <= pend_target_d;
      ce_q          <= ce_d;
    end
  end

`ifdef PIPE_CTRL_DELAY_SLOT_EN
  assign flush = 1'b0;
`else
  assign flush = branch_flag_o;
`endif

endmodule
